// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU function codes, controller states and MIPS opcode/funct constants
package alu_issue_ctrl_pkg;
    typedef enum logic [2:0] {
        F_AND = 3'b000,
        F_OR  = 3'b001,
        F_ADD = 3'b010,
        F_SUB = 3'b110,
        F_SLT = 3'b111
    } alu_f_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request and result valid/ready channels of the ALU issue controller
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [15:0] in_imm;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_y;
    logic        res_zero;
    logic        res_trap;
    logic        res_illegal;
    modport master (
        output in_valid, in_op, in_funct, in_a, in_b, in_imm, res_ready,
        input  in_ready, res_valid, res_y, res_zero, res_trap, res_illegal
    );
    modport slave (
        input  in_valid, in_op, in_funct, in_a, in_b, in_imm, res_ready,
        output in_ready, res_valid, res_y, res_zero, res_trap, res_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_issue_ctrl_decode: opcode/funct to ALU F code, operand B extension, trap enable and illegal flag
module alu_issue_ctrl_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [31:0] i_b,
    output alu_f_t      o_f,
    output logic [31:0] o_b_ext,
    output logic        o_trap_en,
    output logic        o_illegal
);
    always_comb begin
        o_f       = F_AND;
        o_b_ext   = i_b;
        o_trap_en = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  begin o_f = F_ADD; o_trap_en = 1'b1; end
                    FN_ADDU: o_f = F_ADD;
                    FN_SUB:  begin o_f = F_SUB; o_trap_en = 1'b1; end
                    FN_SUBU: o_f = F_SUB;
                    FN_AND:  o_f = F_AND;
                    FN_OR:   o_f = F_OR;
                    FN_SLT:  o_f = F_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin o_f = F_ADD; o_b_ext = sext16(i_imm); o_trap_en = 1'b1; end
            OP_ADDIU: begin o_f = F_ADD; o_b_ext = sext16(i_imm); end
            OP_SLTI:  begin o_f = F_SLT; o_b_ext = sext16(i_imm); end
            OP_ANDI:  begin o_f = F_AND; o_b_ext = zext16(i_imm); end
            OP_ORI:   begin o_f = F_OR;  o_b_ext = zext16(i_imm); end
            OP_BEQ:   o_f = F_SUB;
            default:  o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues decoded MIPS ALU ops to an external ALU and returns registered results.
// Define ALU_ISSUE_PERF_EN to build the perf_ops/perf_traps counters; otherwise they read 0.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_y,
    input  logic             alu_zero,
    input  logic             alu_of,
    output logic [CNT_W-1:0] perf_ops,
    output logic [CNT_W-1:0] perf_traps
);
    state_t      r_state;
    logic [31:0] r_a, r_b, r_y;
    alu_f_t      r_f;
    logic        r_trap_en, r_op_illegal;
    logic        r_valid, r_zero, r_trap, r_illegal;
    alu_f_t      w_f;
    logic [31:0] w_b_ext;
    logic        w_trap_en, w_illegal, w_accept, w_trap;

    alu_issue_ctrl_decode u_decode (
        .i_op      (bus.in_op),
        .i_funct   (bus.in_funct),
        .i_imm     (bus.in_imm),
        .i_b       (bus.in_b),
        .o_f       (w_f),
        .o_b_ext   (w_b_ext),
        .o_trap_en (w_trap_en),
        .o_illegal (w_illegal)
    );

    assign bus.in_ready    = (r_state == IDLE) || (r_state == RESP && bus.res_ready);
    assign w_accept        = bus.in_valid && bus.in_ready;
    assign w_trap          = r_trap_en && alu_of;
    assign alu_a           = r_a;
    assign alu_b           = r_b;
    assign alu_f           = r_f;
    assign bus.res_valid   = r_valid;
    assign bus.res_y       = r_y;
    assign bus.res_zero    = r_zero;
    assign bus.res_trap    = r_trap;
    assign bus.res_illegal = r_illegal;

    // Operand registers only load on accept, so the ALU inputs hold outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_f          <= F_AND;
            r_trap_en    <= 1'b0;
            r_op_illegal <= 1'b0;
            r_valid      <= 1'b0;
            r_y          <= '0;
            r_zero       <= 1'b0;
            r_trap       <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= bus.in_a;
                r_b          <= w_b_ext;
                r_f          <= w_f;
                r_trap_en    <= w_trap_en;
                r_op_illegal <= w_illegal;
            end
            case (r_state)
                IDLE: if (w_accept) r_state <= EXEC;
                EXEC: begin
                    r_state   <= RESP;
                    r_valid   <= 1'b1;
                    r_illegal <= r_op_illegal;
                    r_trap    <= !r_op_illegal && w_trap;
                    r_zero    <= !r_op_illegal && alu_zero;
                    r_y       <= (r_op_illegal || w_trap) ? 32'h0 : alu_y;
                end
                RESP: if (bus.res_ready) begin
                    r_valid <= 1'b0;
                    r_state <= bus.in_valid ? EXEC : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] r_ops, r_traps;
    logic             w_done;
    assign w_done = r_valid && bus.res_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops   <= '0;
            r_traps <= '0;
        end else if (w_done) begin
            r_ops   <= r_ops + CNT_W'(1);
            r_traps <= r_traps + CNT_W'(r_trap);
        end
    end
    assign perf_ops   = r_ops;
    assign perf_traps = r_traps;
`else
    assign perf_ops   = '0;
    assign perf_traps = '0;
`endif
endmodule
